// File: rtl/octal_line_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : octal_line_decoder                                              |
// | Purpose  : 3-bit code stream -> timed one-hot 8-line select pulses with a  |
// |            2-entry input buffer, DWELL drive cycles and GAP blank cycles.  |
// | Options  : PARITY_CHECK_EN adds in_par (even parity) and par_err.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module octal_line_decoder #(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
`ifdef PARITY_CHECK_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic [7:0]       out_onehot,
    output logic             out_active,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] dec_count
);

    localparam int              c_TMAX       = (DWELL > GAP) ? DWELL : GAP;
    localparam int              c_TW         = (c_TMAX < 2) ? 1 : $clog2(c_TMAX);
    localparam logic [c_TW-1:0] c_DWELL_LOAD = c_TW'(DWELL - 1);
    localparam logic [c_TW-1:0] c_GAP_LOAD   = c_TW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit              c_HAS_GAP    = (GAP > 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // ---------------------------------------------------------------- buffer
    logic [2:0]       r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_fifo_cnt;
    logic             w_fifo_empty;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_head;

    // ---------------------------------------------------------------- sequencer
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_TW-1:0]  r_tmr;
    logic [c_TW-1:0]  w_tmr_nxt;
    logic [2:0]       r_code;
    logic [2:0]       w_code_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_dec_cnt;

    assign in_ready     = !rst && (r_fifo_cnt < 2'd2);
    assign w_accept     = in_valid && in_ready;
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_head       = r_mem[r_rd_ptr];

`ifdef PARITY_CHECK_EN
    logic w_par_ok;
    logic r_par_err;

    // A handshake with bad parity is consumed but never reaches the buffer.
    assign w_par_ok = (in_par == ^in_code);
    assign w_push   = w_accept && w_par_ok;
    assign par_err  = r_par_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_accept && !w_par_ok;
        end
    end
`else
    assign w_push = w_accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0]   <= 3'd0;
            r_mem[1]   <= 3'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_code;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_code_nxt  = r_code;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_pop = !w_fifo_empty;
            end
            c_ST_DRIVE: begin
                if (r_tmr == '0) begin
                    w_done_nxt = 1'b1;
                    if (c_HAS_GAP) begin
                        w_tmr_nxt   = c_GAP_LOAD;
                        w_state_nxt = c_ST_GAP;
                    end else if (!w_fifo_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_tmr == '0) begin
                    if (!w_fifo_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        // Every pop starts a fresh DWELL window, whichever state it came from.
        if (w_pop) begin
            w_state_nxt = c_ST_DRIVE;
            w_code_nxt  = w_head;
            w_tmr_nxt   = c_DWELL_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_tmr     <= '0;
            r_code    <= 3'd0;
            r_done    <= 1'b0;
            r_dec_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_code  <= w_code_nxt;
            r_done  <= w_done_nxt;
            if (w_pop) begin
                r_dec_cnt <= r_dec_cnt + 1'b1;
            end
        end
    end

    assign out_active = (r_state == c_ST_DRIVE);
    assign out_onehot = out_active ? (8'd1 << r_code) : 8'd0;
    assign done       = r_done;
    assign busy       = (r_state != c_ST_IDLE) || !w_fifo_empty;
    assign dec_count  = r_dec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_octal_line_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_octal_line_decoder                                           |
// | Purpose  : two decoder instances (with / without GAP) against a queue and  |
// |            timer model of the code-to-line sequencing rules.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_octal_line_decoder;

    localparam int D0 = 4, G0 = 1, C0 = 16;
    localparam int D1 = 4, G1 = 0, C1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       vld  [2];
    logic [2:0] code [2];
    logic       rdy  [2];
    logic [7:0] oh   [2];
    logic       act  [2];
    logic       dn   [2];
    logic       bsy  [2];
    logic [C0-1:0] cnt0;
    logic [C1-1:0] cnt1;
`ifdef PARITY_CHECK_EN
    logic       par  [2];
    logic       perr [2];
`endif

    int total = 0;
    int bad   = 0;

    // Model: queue of accepted codes plus remaining drive / blank cycle counts.
    int          mdl   [2];
    int          mgl   [2];
    int          msize [2];
    logic [2:0]  mbuf  [2][2];
    logic [2:0]  mcur  [2];
    int unsigned mcnt  [2];
    logic        mdone [2];
    logic        mperr [2];
    int          mdw   [2] = '{D0, D1};
    int          mgp   [2] = '{G0, G1};
    int          mcw   [2] = '{C0, C1};

    always #5 clk = ~clk;

    octal_line_decoder #(.DWELL(D0), .GAP(G0), .CNT_W(C0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (vld[0]),
        .in_ready   (rdy[0]),
        .in_code    (code[0]),
`ifdef PARITY_CHECK_EN
        .in_par     (par[0]),
        .par_err    (perr[0]),
`endif
        .out_onehot (oh[0]),
        .out_active (act[0]),
        .done       (dn[0]),
        .busy       (bsy[0]),
        .dec_count  (cnt0)
    );

    octal_line_decoder #(.DWELL(D1), .GAP(G1), .CNT_W(C1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (vld[1]),
        .in_ready   (rdy[1]),
        .in_code    (code[1]),
`ifdef PARITY_CHECK_EN
        .in_par     (par[1]),
        .par_err    (perr[1]),
`endif
        .out_onehot (oh[1]),
        .out_active (act[1]),
        .done       (dn[1]),
        .busy       (bsy[1]),
        .dec_count  (cnt1)
    );

    task automatic model_clear();
        for (int id = 0; id < 2; id++) begin
            mdl[id]   = 0;
            mgl[id]   = 0;
            msize[id] = 0;
            mcur[id]  = 3'd0;
            mcnt[id]  = 0;
            mdone[id] = 1'b0;
            mperr[id] = 1'b0;
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [2:0] c);
        vld[id]  = v;
        code[id] = c;
`ifdef PARITY_CHECK_EN
        par[id]  = ^c;
`endif
    endtask

    // Advance the model with the inputs the DUT is about to see, then clock.
    task automatic step();
        if (rst) begin
            model_clear();
        end else begin
            for (int id = 0; id < 2; id++) begin
                logic push, ok, start;
                push  = vld[id] && (msize[id] < 2);
                ok    = 1'b1;
`ifdef PARITY_CHECK_EN
                ok    = (par[id] == ^code[id]);
`endif
                mperr[id] = push && !ok;
                mdone[id] = 1'b0;
                start     = 1'b0;
                if (mdl[id] > 0) begin
                    mdl[id]--;
                    if (mdl[id] == 0) begin
                        mdone[id] = 1'b1;
                        mgl[id]   = mgp[id];
                        start     = (mgp[id] == 0) && (msize[id] > 0);
                    end
                end else if (mgl[id] > 0) begin
                    mgl[id]--;
                    start = (mgl[id] == 0) && (msize[id] > 0);
                end else begin
                    start = (msize[id] > 0);
                end
                if (start) begin
                    mcur[id]    = mbuf[id][0];
                    mbuf[id][0] = mbuf[id][1];
                    msize[id]--;
                    mdl[id]     = mdw[id];
                    mcnt[id]++;
                end
                if (push && ok) begin
                    mbuf[id][msize[id]] = code[id];
                    msize[id]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 1'b0, 3'd0);
        drive(1, 1'b0, 3'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    // {onehot, active, done, busy, ready, par_err, count}
    function automatic logic [28:0] exp_vec(input int id);
        logic [7:0]  eoh;
        logic [31:0] ec;
        logic        ep;
        eoh = (mdl[id] > 0) ? (8'd1 << mcur[id]) : 8'd0;
        ec  = mcnt[id] & ((32'd1 << mcw[id]) - 32'd1);
        ep  = 1'b0;
`ifdef PARITY_CHECK_EN
        ep  = mperr[id];
`endif
        return {eoh, mdl[id] > 0, mdone[id], (mdl[id] > 0) || (mgl[id] > 0) || (msize[id] > 0),
                !rst && (msize[id] < 2), ep, ec[15:0]};
    endfunction

    function automatic logic [28:0] obs_vec(input int id);
        logic [15:0] oc;
        logic        op;
        oc = (id == 0) ? 16'(cnt0) : 16'(cnt1);
        op = 1'b0;
`ifdef PARITY_CHECK_EN
        op = perr[id];
`endif
        return {oh[id], act[id], dn[id], bsy[id], rdy[id], op, oc};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 3'd4);
        drive(1, 1'b1, 3'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            for (int id = 0; id < 2; id++) begin
                total++;
                if (obs_vec(id) !== exp_vec(id)) begin
                    bad++;
                    $display("FAIL reset dut%0d k=%0d got=%h want=%h", id, k, obs_vec(id), exp_vec(id));
                end
            end
        end
        drive(0, 1'b0, 3'd0);
        drive(1, 1'b0, 3'd0);
        rst = 1'b0;
        #1;
        for (int id = 0; id < 2; id++) begin
            total++;
            if (obs_vec(id) !== exp_vec(id)) begin
                bad++;
                $display("FAIL reset_release dut%0d got=%h want=%h", id, obs_vec(id), exp_vec(id));
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive(0, 1'b1, 3'd5);
        for (int cyc = 0; cyc < 9; cyc++) begin
            step();
            drive(0, 1'b0, 3'd0);
            total++;
            if (obs_vec(0) !== exp_vec(0)) begin
                bad++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        total++;
        if (cnt0 !== 16'd1 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_end count=%0d busy=%b want count=1 busy=0", cnt0, bsy[0]);
        end
    endtask

    task automatic test_stream();
        logic [2:0] lst [3] = '{3'd0, 3'd7, 3'd2};
        int  k = 0, dones = 0;
        logic acc, sawfull;
        sawfull = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = 1'b0;
            if (k < 3) begin
                acc = (msize[0] < 2);
                drive(0, 1'b1, lst[k]);
            end else begin
                drive(0, 1'b0, 3'd0);
            end
            step();
            if (acc) k++;
            if (dn[0] === 1'b1) dones++;
            if (rdy[0] === 1'b0) sawfull = 1'b1;
            total++;
            if (obs_vec(0) !== exp_vec(0)) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        total++;
        if (dones != 3 || cnt0 !== 16'd3 || sawfull !== 1'b1) begin
            bad++;
            $display("FAIL stream_end dones=%0d count=%0d full_seen=%b want 3/3/1", dones, cnt0, sawfull);
        end
    endtask

    task automatic test_gap0();
        int run = 0, maxrun = 0;
        apply_reset();
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc == 0)      drive(1, 1'b1, 3'd1);
            else if (cyc == 1) drive(1, 1'b1, 3'd2);
            else               drive(1, 1'b0, 3'd0);
            step();
            run    = (act[1] === 1'b1) ? run + 1 : 0;
            maxrun = (run > maxrun) ? run : maxrun;
            total++;
            if (obs_vec(1) !== exp_vec(1)) begin
                bad++;
                $display("FAIL gap0 cyc=%0d got=%h want=%h", cyc, obs_vec(1), exp_vec(1));
            end
        end
        total++;
        if (maxrun != 8) begin
            bad++;
            $display("FAIL gap0_active_run got=%0d want=8", maxrun);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        apply_reset();
        drive(0, 1'b1, 3'd6);
        step();
        drive(0, 1'b1, 3'd3);
        step();
        drive(0, 1'b0, 3'd0);
        step();
        total++;
        if (obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL rstmid_pre got=%h want=%h", obs_vec(0), exp_vec(0));
        end
        rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (oh[0] !== 8'h00 || cnt0 !== 16'd0 || obs_vec(0) !== exp_vec(0)) begin
            bad++;
            $display("FAIL rstmid_async got=%h want=%h", obs_vec(0), exp_vec(0));
        end
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (oh[0] === 8'h08) seen = 1'b1;
            total++;
            if (obs_vec(0) !== exp_vec(0)) begin
                bad++;
                $display("FAIL rstmid_after cyc=%0d got=%h want=%h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_discard buffered code driven got=%b want=0", seen);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] lst [5]  = '{3'd3, 3'd6, 3'd0, 3'd5, 3'd1};
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] seq  [8];
        logic [1:0] prev;
        int   k = 0, nseq = 0;
        logic acc;
        apply_reset();
        prev = cnt1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = 1'b0;
            if (k < 5) begin
                acc = (msize[1] < 2);
                drive(1, 1'b1, lst[k]);
            end else begin
                drive(1, 1'b0, 3'd0);
            end
            step();
            if (acc) k++;
            if (cnt1 !== prev && nseq < 8) begin
                seq[nseq] = cnt1;
                nseq++;
            end
            prev = cnt1;
            total++;
            if (obs_vec(1) !== exp_vec(1)) begin
                bad++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs_vec(1), exp_vec(1));
            end
        end
        total++;
        if (nseq != 5) begin
            bad++;
            $display("FAIL wrap_len got=%0d want=5", nseq);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (seq[i] !== want[i]) begin
                    bad++;
                    $display("FAIL wrap_seq[%0d] got=%0d want=%0d", i, seq[i], want[i]);
                end
            end
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        int pulses = 0, win = 0;
        apply_reset();
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc == 0) begin
                drive(0, 1'b1, 3'd3);
                par[0] = 1'b1;
            end else if (cyc == 1) begin
                drive(0, 1'b1, 3'd3);
            end else begin
                drive(0, 1'b0, 3'd0);
            end
            step();
            if (perr[0] === 1'b1) pulses++;
            if (oh[0] === 8'h08) win++;
            total++;
            if (obs_vec(0) !== exp_vec(0)) begin
                bad++;
                $display("FAIL parity cyc=%0d got=%h want=%h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        total++;
        if (pulses != 1 || win != 4 || cnt0 !== 16'd1) begin
            bad++;
            $display("FAIL parity_end pulses=%0d drive_cycles=%0d count=%0d want 1/4/1", pulses, win, cnt0);
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int id = 0; id < 2; id++) begin
                drive(id, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
`ifdef PARITY_CHECK_EN
                if ($urandom_range(0, 7) == 0) par[id] = ~par[id];
`endif
            end
            step();
            for (int id = 0; id < 2; id++) begin
                total++;
                if (obs_vec(id) !== exp_vec(id)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got=%h want=%h", id, cyc, obs_vec(id), exp_vec(id));
                end
            end
        end
    endtask

    initial begin
        model_clear();
        drive(0, 1'b0, 3'd0);
        drive(1, 1'b0, 3'd0);
        test_reset();
        test_single();
        test_stream();
        test_gap0();
        test_reset_mid();
        test_wrap();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/octal_line_decoder.md
Name: octal_line_decoder

Overview:
- Inverse of the team's 8-to-3 one-hot encoder: converts a stream of 3-bit binary codes into timed one-hot 8-line select pulses.
- Codes arrive on a valid/ready interface and pass through a 2-entry buffer.
- An output FSM drives each decoded line for DWELL cycles, followed by a break-before-make GAP of all-zero outputs.
- Used to sequence eight downstream enables (mux legs, LED/relay lines) from a compact code source.

Parameters:
DWELL, 4, cycles each one-hot word is driven; legal range >=1
GAP, 1, all-zero cycles inserted after each DWELL; legal range >=0
CNT_W, 16, width of decoded-word counter

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_code is valid
in_ready  output  1  block can accept a code this cycle
in_code  input  3  binary code 0..7
out_onehot  output  8  decoded line, bit n set for code n; zero when not driving
out_active  output  1  high while in DRIVE
done  output  1  one-cycle pulse after each DWELL completes
busy  output  1  FSM not IDLE or buffer non-empty
dec_count  output  CNT_W  number of words decoded, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM in IDLE; out_onehot=0, out_active=0, done=0, busy=0, dec_count=0, in_ready=0.
- Reset mid-operation: outputs clear immediately on rst assertion. Buffered codes are discarded; done is not pulsed.
- in_ready = !rst && (fifo_count<2). A push occurs on a rising edge with in_valid && in_ready.
- When full, no push is accepted, even in a cycle where a pop occurs; in_ready depends on count only.
- in_code is captured only on push; it is ignored otherwise.
- FIFO: 2 entries, first-in first-out. A simultaneous push and pop, with count 1, leaves count at 1.
- IDLE:
  - If the FIFO is non-empty: pop at the edge, load code, counter=DWELL-1, go to DRIVE.
  - Result: a code pushed at edge N into an empty FIFO while IDLE drives out_onehot from edge N+1 (1-cycle latency).
- DRIVE:
  - out_onehot = 8'b1 << code; out_active=1; counter decrements each cycle.
  - On the edge where counter==0:
    - done=1 for the following cycle.
    - If GAP>0: counter=GAP-1, go to GAP.
    - If GAP==0 and FIFO non-empty: pop, load next code, reload DWELL-1, stay in DRIVE. There is no zero cycle between words.
    - If GAP==0 and FIFO empty: go to IDLE.
- GAP:
  - out_onehot=0, out_active=0; counter decrements.
  - At counter==0: if FIFO non-empty, pop and go to DRIVE; else go to IDLE.
- dec_count increments by 1 on every edge that enters or reloads DRIVE; it wraps to 0.
- Invariant: out_onehot is always exactly one-hot (DRIVE) or all-zero (all other states); never multi-hot.
- done is registered, and never high in two consecutive cycles when DWELL>=2.
- busy = (state!=IDLE) || (fifo_count!=0).

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Adds input in_par (1 bit, even parity over in_code) and output par_err (1 bit).
  - A pushed code whose parity mismatches is dropped at the push edge: not written to the FIFO, not counted.
  - par_err pulses high for one cycle following that edge.
- Undefined: ports in_par and par_err do not exist; every accepted code is decoded.

Test Plan:
1. DWELL=4, GAP=1; push code 5 at edge 0 from idle -> out_onehot=8'h20 for cycles 1-4; 8'h00 at cycle 5; done=1 at cycle 5; dec_count=1; busy=0 from cycle 6.
2. DWELL=4, GAP=1; in_valid held with codes 0,7,2 -> out_onehot 8'h01, 8'h80, 8'h04, each 4 cycles, separated by one 8'h00 cycle; in_ready=0 while 2 entries buffered; dec_count=3; three done pulses.
3. DWELL=4, GAP=0; codes 1,2 pushed back-to-back -> 8'h02 for 4 cycles then 8'h04 for 4 cycles with no zero cycle between; out_active stays high for 8 cycles.
4. Assert rst at cycle 2 of a DRIVE with one code buffered -> out_onehot=0 and dec_count=0 before the next edge; after release busy=0 and the buffered code is never driven.
5. CNT_W=2; decode 5 codes -> dec_count sequence 1,2,3,0,1.
6. With PARITY_CHECK_EN: push code 3 with in_par=1 (bad) then code 3 with in_par=0 -> par_err pulses once; only one 8'h08 window is driven; dec_count=1.
